// File: rtl/rv64g_l2_array_bank.sv
// rv64g_l2_array_bank
//   Set-associative L2 data/tag/state array bank with a registered
//   request/response interface. It supports four operations:
//     LOOKUP  - tag compare across all ways of a set. The response carries the
//               lowest hitting way together with its data word, tag and state.
//     WR_DATA - byte-enabled write of one word.
//     WR_TAG  - write of the tag and coherence state of one way.
//     BURST   - critical-word-first line read of WORDS beats, wrapping.
//   After reset the bank sweeps all sets, clearing every way's state
//   (one set per cycle). Data and tag contents are left untouched.
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   init_busy_o            invalidation sweep in progress
//   req_*                  request channel (valid/ready handshake)
//   rsp_*                  registered response beat; all zero when not valid
module rv64g_l2_array_bank #(
    parameter int SETS   = 256,
    parameter int WAYS   = 16,
    parameter int WORDS  = 8,
    parameter int TAG_W  = 50,
    parameter int DATA_W = 64,
    parameter int ST_W   = 2,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS),
    localparam int WSEL_W = $clog2(WORDS),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              init_busy_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [IDX_W-1:0]  req_index_i,
    input  logic [WSEL_W-1:0] req_word_i,
    input  logic [WAY_W-1:0]  req_way_i,
    input  logic [BE_W-1:0]   req_be_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    input  logic [ST_W-1:0]   req_state_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic [WAY_W-1:0]  rsp_way_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic [ST_W-1:0]   rsp_state_o,
    output logic              rsp_last_o
);
    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_WDATA  = 2'd1;
    localparam logic [1:0] OP_WTAG   = 2'd2;
    localparam logic [1:0] OP_BURST  = 2'd3;

    localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(SETS - 1);
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(WORDS - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BURST} fsm_e;

    logic [DATA_W-1:0] data_mem [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [ST_W-1:0]   st_mem   [SETS][WAYS];

    fsm_e              fsm_q, fsm_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [WSEL_W-1:0] beat_q, beat_d, bword_q, bword_d;
    logic [IDX_W-1:0]  bidx_q, bidx_d;
    logic [WAY_W-1:0]  bway_q, bway_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_last_q, rsp_last_d;
    logic [WAY_W-1:0]  rsp_way_q, rsp_way_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [ST_W-1:0]   rsp_st_q, rsp_st_d;

    logic              acc, lk_hit, burst_more;
    logic [WAY_W-1:0]  lk_way, rd_way;
    logic [IDX_W-1:0]  rd_idx;
    logic [WSEL_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic [ST_W-1:0]   rd_st;

    assign acc        = req_valid_i & ready_q;
    assign burst_more = (fsm_q == S_BURST) && (beat_q != LAST_WORD);

    // Descending scan so the lowest-index hitting way wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_mem[req_index_i][w] != '0 && tag_mem[req_index_i][w] == req_tag_i) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    // Single read port. It serves either the accepted request or the next
    // burst beat; the two never coincide because ready is low mid-burst.
    always_comb begin
        rd_idx  = bidx_q;
        rd_way  = bway_q;
        rd_word = WSEL_W'(bword_q + beat_q + WSEL_W'(1));
        if (acc) begin
            rd_idx  = req_index_i;
            rd_word = req_word_i;
            rd_way  = (req_op_i == OP_BURST) ? req_way_i : lk_way;
        end
    end
    assign rd_data = data_mem[rd_idx][rd_way][rd_word];
    assign rd_tag  = tag_mem[rd_idx][rd_way];
    assign rd_st   = st_mem[rd_idx][rd_way];

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        bword_d     = bword_q;
        bidx_d      = bidx_q;
        bway_d      = bway_q;
        busy_d      = 1'b0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_way_d   = '0;
        rsp_rdata_d = '0;
        rsp_tag_d   = '0;
        rsp_st_d    = '0;
        rsp_last_d  = 1'b0;
        case (fsm_q)
            S_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_SET) begin
                    fsm_d   = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                if (burst_more) begin
                    beat_d      = beat_q + WSEL_W'(1);
                    rsp_valid_d = 1'b1;
                    rsp_way_d   = bway_q;
                    rsp_rdata_d = rd_data;
                    rsp_tag_d   = rd_tag;
                    rsp_st_d    = rd_st;
                    rsp_last_d  = (beat_d == LAST_WORD);
                    ready_d     = rsp_last_d;
                end else begin
                    // IDLE, or the final-beat cycle of a burst (ready is high there).
                    fsm_d   = S_IDLE;
                    ready_d = 1'b1;
                    if (acc) begin
                        case (req_op_i)
                            OP_LOOKUP: begin
                                rsp_valid_d = 1'b1;
                                rsp_last_d  = 1'b1;
                                rsp_hit_d   = lk_hit;
                                if (lk_hit) begin
                                    rsp_way_d   = lk_way;
                                    rsp_rdata_d = rd_data;
                                    rsp_tag_d   = rd_tag;
                                    rsp_st_d    = rd_st;
                                end
                            end
                            OP_BURST: begin
                                fsm_d       = S_BURST;
                                ready_d     = 1'b0;
                                beat_d      = '0;
                                bword_d     = req_word_i;
                                bidx_d      = req_index_i;
                                bway_d      = req_way_i;
                                rsp_valid_d = 1'b1;
                                rsp_way_d   = req_way_i;
                                rsp_rdata_d = rd_data;
                                rsp_tag_d   = rd_tag;
                                rsp_st_d    = rd_st;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= S_INIT;
            cnt_q       <= '0;
            beat_q      <= '0;
            bword_q     <= '0;
            bidx_q      <= '0;
            bway_q      <= '0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_way_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_tag_q   <= '0;
            rsp_st_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            bword_q     <= bword_d;
            bidx_q      <= bidx_d;
            bway_q      <= bway_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_way_q   <= rsp_way_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_st_q    <= rsp_st_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Array writes: the sweep clears states; requests write at the acceptance edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fsm_q == S_INIT) begin
                for (int w = 0; w < WAYS; w++) st_mem[cnt_q][w] <= '0;
            end
            if (acc && req_op_i == OP_WDATA) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be_i[b])
                        data_mem[req_index_i][req_way_i][req_word_i][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
                end
            end
            if (acc && req_op_i == OP_WTAG) begin
                tag_mem[req_index_i][req_way_i] <= req_tag_i;
                st_mem[req_index_i][req_way_i]  <= req_state_i;
            end
        end
    end

    assign init_busy_o = busy_q;
    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_way_o   = rsp_way_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_state_o = rsp_st_q;
    assign rsp_last_o  = rsp_last_q;
endmodule

// File: tb/tb_rv64g_l2_array_bank.sv
// Self-checking bench for rv64g_l2_array_bank (default geometry).
// It runs directed scenarios followed by a randomized mix of operations. The
// expected values come from a plain array model of the bank. That model tracks
// which data bytes and tags have been written, so never-written contents are
// not compared.
module tb_rv64g_l2_array_bank;
    localparam logic [1:0] OP_LK = 2'd0, OP_WD = 2'd1, OP_WT = 2'd2, OP_BU = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_busy;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_index;
    logic [2:0]  req_word;
    logic [3:0]  req_way;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic [49:0] req_tag;
    logic [1:0]  req_state;
    logic        rsp_valid, rsp_hit, rsp_last;
    logic [3:0]  rsp_way;
    logic [63:0] rsp_rdata;
    logic [49:0] rsp_tag;
    logic [1:0]  rsp_state;

    always #5 clk = ~clk;

    rv64g_l2_array_bank dut (
        .clk_i(clk), .rst_i(rst), .init_busy_o(init_busy),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_index_i(req_index), .req_word_i(req_word), .req_way_i(req_way),
        .req_be_i(req_be), .req_wdata_i(req_wdata), .req_tag_i(req_tag),
        .req_state_i(req_state), .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit),
        .rsp_way_o(rsp_way), .rsp_rdata_o(rsp_rdata), .rsp_tag_o(rsp_tag),
        .rsp_state_o(rsp_state), .rsp_last_o(rsp_last)
    );

    // Reference model
    logic [63:0] m_data [256][16][8];
    logic [7:0]  m_bk   [256][16][8];
    logic [49:0] m_tag  [256][16];
    bit          m_tk   [256][16];
    logic [1:0]  m_st   [256][16];
    logic [49:0] pool   [4];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bmask(input logic [7:0] bk);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{bk[b]}};
        return m;
    endfunction

    task automatic model_lookup(input int idx, input logic [49:0] tg, output bit hit, output int way);
        hit = 0;
        way = 0;
        for (int w = 0; w < 16; w++)
            if (!hit && m_st[idx][w] != 2'd0 && m_tag[idx][w] == tg) begin
                hit = 1;
                way = w;
            end
    endtask

    task automatic send(input logic [1:0] op, input int idx, input int word, input int way,
                        input logic [7:0] be, input logic [63:0] wd, input logic [49:0] tg,
                        input logic [1:0] st, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            ok = 0;
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_index = 8'(idx);
        req_word  = 3'(word);
        req_way   = 4'(way);
        req_be    = be;
        req_wdata = wd;
        req_tag   = tg;
        req_state = st;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1;
        if (op == OP_WD) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) begin
                    m_data[idx][way][word][b*8 +: 8] = wd[b*8 +: 8];
                    m_bk[idx][way][word][b] = 1'b1;
                end
        end else if (op == OP_WT) begin
            m_tag[idx][way] = tg;
            m_tk[idx][way]  = 1'b1;
            m_st[idx][way]  = st;
        end
    endtask

    task automatic wr(input logic [1:0] op, input int idx, input int word, input int way,
                      input logic [7:0] be, input logic [63:0] wd, input logic [49:0] tg,
                      input logic [1:0] st);
        bit ok;
        send(op, idx, word, way, be, wd, tg, st, ok);
        if (!ok) return;
        @(negedge clk);
        chk("wr_no_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("wr_rsp_rdata_zero", rsp_rdata, 64'd0);
    endtask

    task automatic lookup(input int idx, input int word, input logic [49:0] tg, input string nm);
        bit ok, hit;
        int way;
        logic [63:0] mk;
        send(OP_LK, idx, word, 0, 8'h00, 64'd0, tg, 2'd0, ok);
        if (!ok) return;
        model_lookup(idx, tg, hit, way);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_last"}, 64'(rsp_last), 64'd1);
        chk({nm, "_hit"}, 64'(rsp_hit), 64'(hit));
        if (hit) begin
            mk = bmask(m_bk[idx][way][word]);
            chk({nm, "_way"}, 64'(rsp_way), 64'(way));
            chk({nm, "_tag"}, 64'(rsp_tag), 64'(m_tag[idx][way]));
            chk({nm, "_state"}, 64'(rsp_state), 64'(m_st[idx][way]));
            chk({nm, "_rdata"}, rsp_rdata & mk, m_data[idx][way][word] & mk);
        end else begin
            chk({nm, "_miss_way"}, 64'(rsp_way), 64'd0);
            chk({nm, "_miss_rdata"}, rsp_rdata, 64'd0);
            chk({nm, "_miss_tag"}, 64'(rsp_tag), 64'd0);
            chk({nm, "_miss_state"}, 64'(rsp_state), 64'd0);
        end
    endtask

    task automatic reset_and_sweep(input int nhold);
        int n;
        bit rdy_bad;
        rst = 1'b1;
        repeat (nhold) begin
            @(negedge clk);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_last", 64'(rsp_last), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end
        rst = 1'b0;
        n = 0;
        rdy_bad = 0;
        while (init_busy && n < 1000) begin
            if (req_ready) rdy_bad = 1;
            n++;
            @(negedge clk);
        end
        chk("init_busy_cycles", 64'(n), 64'd256);
        chk("init_ready_low", 64'(rdy_bad), 64'd0);
        chk("post_init_ready", 64'(req_ready), 64'd1);
        chk("post_init_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 16; w++) m_st[s][w] = 2'd0;
    endtask

    // abort >= 0 asserts reset during that beat and then re-runs the sweep.
    task automatic burst(input int idx, input int way, input int start, input int abort, input string nm);
        bit ok;
        int wd;
        logic [63:0] mk;
        send(OP_BU, idx, start, way, 8'h00, 64'd0, 50'd0, 2'd0, ok);
        if (!ok) return;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wd = (start + k) % 8;
            mk = bmask(m_bk[idx][way][wd]);
            chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, "_hit"}, 64'(rsp_hit), 64'd0);
            chk({nm, "_way"}, 64'(rsp_way), 64'(way));
            chk({nm, "_rdata"}, rsp_rdata & mk, m_data[idx][way][wd] & mk);
            chk({nm, "_state"}, 64'(rsp_state), 64'(m_st[idx][way]));
            if (m_tk[idx][way]) chk({nm, "_tag"}, 64'(rsp_tag), 64'(m_tag[idx][way]));
            chk({nm, "_last"}, 64'(rsp_last), 64'(k == 7));
            chk({nm, "_ready"}, 64'(req_ready), 64'(k == 7));
            if (k == abort) begin
                reset_and_sweep(2);
                return;
            end
        end
    endtask

    initial begin
        logic [49:0] t2, tx, ty;
        int r, idx, way, word;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'd0; req_index = '0; req_word = '0; req_way = '0;
        req_be = '0; req_wdata = '0; req_tag = '0; req_state = '0;
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 16; w++) begin
                m_tk[s][w] = 0;
                m_st[s][w] = 2'd0;
                m_tag[s][w] = '0;
                for (int k = 0; k < 8; k++) begin
                    m_bk[s][w][k] = 8'h00;
                    m_data[s][w][k] = 64'd0;
                end
            end
        pool[0] = 50'h123456789ABC; pool[1] = 50'h3FFFF00000001;
        pool[2] = 50'h0; pool[3] = 50'h2AAAA5555AAAA;
        t2 = 50'h123456789ABC;
        tx = 50'h0BEEF0000CAFE;
        ty = 50'h1F00D0000D00D;

        repeat (2) @(posedge clk);
        // 1. reset sweep, then a miss
        reset_and_sweep(3);
        lookup(8'h10, 0, 50'd0, "t1_lookup");

        // 2. write and hit
        wr(OP_WT, 8'h10, 0, 5, 8'h00, 64'd0, t2, 2'd2);
        wr(OP_WD, 8'h10, 2, 5, 8'hFF, 64'hDEADBEEFCAFEBABE, 50'd0, 2'd0);
        lookup(8'h10, 2, t2, "t2_hit");

        // 3. partial write
        wr(OP_WD, 8'h10, 2, 5, 8'h0F, 64'h11111111, 50'd0, 2'd0);
        lookup(8'h10, 2, t2, "t3_partial");
        chk("t3_model_value", m_data[8'h10][5][2], 64'hDEADBEEF11111111);

        // 4. wrapped burst
        for (int w = 0; w < 8; w++) wr(OP_WD, 8'h10, w, 5, 8'hFF, 64'(w), 50'd0, 2'd0);
        burst(8'h10, 5, 6, -1, "t4_burst");

        // 5. priority and invalidate
        wr(OP_WT, 8'h20, 0, 9, 8'h00, 64'd0, tx, 2'd3);
        wr(OP_WT, 8'h20, 0, 3, 8'h00, 64'd0, tx, 2'd1);
        wr(OP_WD, 8'h20, 4, 3, 8'hFF, 64'hAAAA000033330003, 50'd0, 2'd0);
        wr(OP_WD, 8'h20, 4, 9, 8'hFF, 64'hBBBB000099990009, 50'd0, 2'd0);
        lookup(8'h20, 4, tx, "t5_way3");
        wr(OP_WT, 8'h20, 0, 3, 8'h00, 64'd0, tx, 2'd0);
        lookup(8'h20, 4, tx, "t5_way9");
        wr(OP_WT, 8'h20, 0, 9, 8'h00, 64'd0, tx, 2'd0);
        lookup(8'h20, 4, tx, "t5_miss");

        // randomized mix over a few sets, with a small tag pool to force hits
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            idx = $urandom_range(0, 3);
            way = $urandom_range(0, 15);
            word = $urandom_range(0, 7);
            if (r <= 2)
                wr(OP_WT, idx, 0, way, 8'h00, 64'd0, pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)));
            else if (r <= 5)
                wr(OP_WD, idx, word, way, 8'($urandom), {$urandom, $urandom}, 50'd0, 2'd0);
            else if (r <= 8)
                lookup(idx, word, pool[$urandom_range(0, 3)], "rnd_lookup");
            else
                burst(idx, way, word, -1, "rnd_burst");
        end

        // 6. reset mid-burst
        wr(OP_WT, 8'h30, 0, 2, 8'h00, 64'd0, ty, 2'd1);
        for (int w = 0; w < 8; w++) wr(OP_WD, 8'h30, w, 2, 8'hFF, 64'(100 + w), 50'd0, 2'd0);
        lookup(8'h30, 1, ty, "t6_pre_hit");
        burst(8'h30, 2, 5, 3, "t6_burst");
        lookup(8'h30, 1, ty, "t6_post_miss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
